lot_gate_controller: RTL and testbench

//  Occupancy controller for the parking lot, downstream of the a/b sensor FSM.
//  - Counts cars from that FSM's one-cycle inc/dec pulses.
//  - Drives the entry and exit barrier gates, refusing entry when the lot is full.
//  - Flags sticky overflow/underflow errors when sensor pulses are inconsistent.

---
 rtl/lot_pkg.sv | 13 +
 rtl/lot_gate_fsm.sv | 54 +++++
 rtl/lot_gate_controller.sv | 95 +++++++++
 tb/tb_lot_gate_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lot_pkg.sv
// Shared constants for the parking-lot occupancy controller.
// The gate state encoding is used by lot_gate_fsm.
package lot_pkg;

    localparam logic GATE_IDLE = 1'b0;
    localparam logic GATE_OPEN = 1'b1;

    localparam int unsigned DEF_CAPACITY     = 8;
    localparam int unsigned DEF_CNT_W        = 4;
    localparam int unsigned DEF_GATE_TIMEOUT = 16;
    localparam int unsigned DEF_TO_W         = 5;

endpackage

// File: rtl/lot_gate_fsm.sv
// Single barrier gate: opens on an allowed request, closes on a passage pulse
// or after GATE_TIMEOUT cycles with nobody passing.
module lot_gate_fsm
    import lot_pkg::*;
#(
    parameter int unsigned GATE_TIMEOUT = DEF_GATE_TIMEOUT,
    parameter int unsigned TO_W         = DEF_TO_W
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic allow,
    input  logic pass,
    output logic open
);

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(GATE_TIMEOUT - 1);

    logic            state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (state_q == GATE_IDLE) begin
            if (req && allow) begin
                state_d = GATE_OPEN;
                timer_d = '0;
            end
        end else begin
            // A pass pulse wins over the timeout when both land on the same edge.
            if (pass) begin
                state_d = GATE_IDLE;
            end else if (timer_q == TIMER_LAST) begin
                state_d = GATE_IDLE;
            end else begin
                timer_d = timer_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= GATE_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign open = (state_q == GATE_OPEN);

endmodule

// File: rtl/lot_gate_controller.sv
// Parking-lot occupancy controller: saturating car counter with sticky
// over/underflow flags, plus independent entry and exit barrier gates.
module lot_gate_controller
    import lot_pkg::*;
#(
    parameter int unsigned CAPACITY     = DEF_CAPACITY,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned GATE_TIMEOUT = DEF_GATE_TIMEOUT,
    parameter int unsigned TO_W         = DEF_TO_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             entry_open,
    output logic             exit_open,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] CAP_COUNT = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    assign full  = (count_q == CAP_COUNT);
    assign empty = (count_q == '0);

    // Simultaneous inc and dec is a net-zero move and never flags an error.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (inc && !dec) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count         = count_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

    lot_gate_fsm #(
        .GATE_TIMEOUT (GATE_TIMEOUT),
        .TO_W         (TO_W)
    ) u_entry_gate (
        .clk   (clk),
        .reset (reset),
        .req   (entry_req),
        .allow (!full),
        .pass  (inc),
        .open  (entry_open)
    );

    lot_gate_fsm #(
        .GATE_TIMEOUT (GATE_TIMEOUT),
        .TO_W         (TO_W)
    ) u_exit_gate (
        .clk   (clk),
        .reset (reset),
        .req   (exit_req),
        .allow (1'b1),
        .pass  (dec),
        .open  (exit_open)
    );

endmodule

// File: tb/tb_lot_gate_controller.sv
// Directed bench for lot_gate_controller with CAPACITY=2, GATE_TIMEOUT=4.
// Status vector layout: {count[3:0], full, empty, entry_open, exit_open, ovf, unf}.
module tb_lot_gate_controller;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       inc;
    logic       dec;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       entry_open;
    logic       exit_open;
    logic       overflow_err;
    logic       underflow_err;
    logic [9:0] st;

    int checks   = 0;
    int failures = 0;

    lot_gate_controller #(
        .CAPACITY     (2),
        .CNT_W        (4),
        .GATE_TIMEOUT (4),
        .TO_W         (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .inc           (inc),
        .dec           (dec),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .entry_open    (entry_open),
        .exit_open     (exit_open),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    assign st = {count, full, empty, entry_open, exit_open, overflow_err, underflow_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        apply_reset();
        exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", st, exp);
        end
        inc = 1'b1;
        step();
        inc = 1'b0;
        exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL reset_pre_inc: got %b expected %b", st, exp);
        end
        entry_req = 1'b1;
        step();
        exp = {4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL reset_pre_open: got %b expected %b", st, exp);
        end
        #2;
        reset = 1'b0;
        #1;
        exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL reset_async_drop: got %b expected %b", st, exp);
        end
        step();
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL reset_hold: got %b expected %b", st, exp);
        end
        entry_req = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic test_entry();
        logic [9:0] exp;
        entry_req = 1'b1;
        step();
        exp = {4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (st !== exp) begin
                failures++;
                $display("FAIL entry_open_cycle%0d: got %b expected %b", i, st, exp);
            end
            if (i < 2) step();
        end
        inc       = 1'b1;
        entry_req = 1'b0;
        step();
        inc = 1'b0;
        exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL entry_close_on_inc: got %b expected %b", st, exp);
        end
        step();
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL entry_stays_closed: got %b expected %b", st, exp);
        end
    endtask

    task automatic test_full();
        logic [9:0] exp;
        inc = 1'b1;
        step();
        inc = 1'b0;
        exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL full_reached: got %b expected %b", st, exp);
        end
        entry_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (st !== exp) begin
                failures++;
                $display("FAIL full_entry_refused%0d: got %b expected %b", i, st, exp);
            end
        end
        dec = 1'b1;
        step();
        dec = 1'b0;
        exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL full_dec_edge: got %b expected %b", st, exp);
        end
        step();
        exp = {4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL full_reopen: got %b expected %b", st, exp);
        end
        inc = 1'b1;
        step();
        inc = 1'b0;
        exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL full_close_on_inc: got %b expected %b", st, exp);
        end
        step();
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL full_no_second_admit: got %b expected %b", st, exp);
        end
        entry_req = 1'b0;
    endtask

    task automatic test_timeout();
        logic [9:0] exp;
        exit_req = 1'b1;
        step();
        exit_req = 1'b0;
        exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (st !== exp) begin
                failures++;
                $display("FAIL timeout_open%0d: got %b expected %b", i, st, exp);
            end
            step();
        end
        exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL timeout_closed: got %b expected %b", st, exp);
        end
        step();
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL timeout_stays_closed: got %b expected %b", st, exp);
        end
    endtask

    task automatic test_errors();
        logic [9:0] exp;
        inc = 1'b1;
        step();
        inc = 1'b0;
        exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL overflow_set: got %b expected %b", st, exp);
        end
        dec = 1'b1;
        step();
        step();
        dec = 1'b0;
        exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL drain_to_empty: got %b expected %b", st, exp);
        end
        dec = 1'b1;
        step();
        dec = 1'b0;
        exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL underflow_set: got %b expected %b", st, exp);
        end
        step();
        step();
        step();
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL errors_sticky: got %b expected %b", st, exp);
        end
        inc = 1'b1;
        step();
        inc = 1'b0;
        exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL errors_persist_after_inc: got %b expected %b", st, exp);
        end
        apply_reset();
        exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL errors_cleared_by_reset: got %b expected %b", st, exp);
        end
    endtask

    task automatic test_simultaneous();
        logic [9:0] exp;
        inc = 1'b1;
        dec = 1'b1;
        step();
        inc = 1'b0;
        dec = 1'b0;
        exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL simul_at_empty: got %b expected %b", st, exp);
        end
        inc = 1'b1;
        step();
        step();
        inc = 1'b0;
        exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL fill_again: got %b expected %b", st, exp);
        end
        inc = 1'b1;
        dec = 1'b1;
        step();
        inc = 1'b0;
        dec = 1'b0;
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL simul_at_full: got %b expected %b", st, exp);
        end
        dec = 1'b1;
        step();
        dec = 1'b0;
        exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL simul_prep_dec: got %b expected %b", st, exp);
        end
        entry_req = 1'b1;
        exit_req  = 1'b1;
        step();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exp = {4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL both_open: got %b expected %b", st, exp);
        end
        inc = 1'b1;
        step();
        inc = 1'b0;
        exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL entry_closes_own_pass: got %b expected %b", st, exp);
        end
        dec = 1'b1;
        step();
        dec = 1'b0;
        exp = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (st !== exp) begin
            failures++;
            $display("FAIL exit_closes_own_pass: got %b expected %b", st, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        test_reset();
        test_entry();
        test_full();
        test_timeout();
        test_errors();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
